multiseg_scan_driver: RTL

- Parametrised time-multiplexed driver for a common-anode multi-digit 7-segment display, fed with packed BCD.
- Successor to the fixed 4-digit multiseg driver. Adds digit count, refresh rate and pin-polarity parameters.
- New behaviour: frame-synchronous input snapshot (no tearing), 16-level brightness PWM, leading-zero blanking, per-digit decimal point, anode guard cycle, and enable.
- Sits between the BCD counter/formatter logic and the board's anode/cathode pins.

---
 rtl/multiseg_pkg.sv | 42 ++++
 rtl/multiseg_scan_driver_seg7_decode.sv | 11 +
 rtl/multiseg_scan_driver.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/multiseg_pkg.sv
// Shared segment glyphs, BCD decode function and PWM helpers for the scan driver.
package multiseg_pkg;

  localparam int unsigned PWM_LEVELS = 16;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Clocks per brightness level within one digit slot
  function automatic int unsigned pwm_step(input int unsigned refresh_div);
    return refresh_div / PWM_LEVELS;
  endfunction

endpackage

// File: rtl/multiseg_scan_driver_seg7_decode.sv
// Combinational BCD nibble to active-high 7-segment pattern; invalid nibbles go dark.
module seg7_decode
  import multiseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  assign seg_c = bcd_to_seg(nibble);

endmodule

// File: rtl/multiseg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame snapshot, PWM dimming,
// leading-zero blanking, per-digit dp and a guard cycle at the start of each slot.
module multiseg_scan_driver
  import multiseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned REFRESH_DIV      = 1024,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   seg_anode,
  output logic [6:0]              seg_cathode,
  output logic                    seg_dp,
  output logic                    frame_tick
);

  localparam int unsigned PW   = $clog2(REFRESH_DIV);
  localparam int unsigned TW   = PW + 1;
  localparam int unsigned DW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned STEP = pwm_step(REFRESH_DIV);

  // XOR masks: all-ones when the pin is active low, giving both the idle level and the inversion
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ANODE_ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF   = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF    = SEG_ACTIVE_LOW;

  logic [PW-1:0]           p_q;
  logic [DW-1:0]           d_q;
  logic [4*NUM_DIGITS-1:0] bcd_s;
  logic [NUM_DIGITS-1:0]   dp_s;
  logic                    blz_s;
  logic [3:0]              bright_l;

  logic                  p_last_c;
  logic                  d_last_c;
  logic                  frame_start_c;
  logic [3:0]            nibble_c;
  logic                  dp_sel_c;
  logic                  blank_c;
  logic                  upper_zero_c;
  logic [6:0]            dec_seg_c;
  logic [6:0]            seg_c;
  logic [NUM_DIGITS-1:0] anode_hot_c;
  logic [TW-1:0]         thresh_c;
  logic                  lit_c;

  assign p_last_c      = (p_q == PW'(REFRESH_DIV - 1));
  assign d_last_c      = (d_q == DW'(NUM_DIGITS - 1));
  assign frame_start_c = (p_q == '0) && (d_q == '0);

  // Select the current digit's nibble and dp from the shadow copy
  always_comb begin
    nibble_c = '0;
    dp_sel_c = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (d_q == DW'(k)) begin
        nibble_c = bcd_s[4*k +: 4];
        dp_sel_c = dp_s[k];
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows
  always_comb begin
    blank_c      = 1'b0;
    upper_zero_c = 1'b1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      upper_zero_c = upper_zero_c && (bcd_s[4*k +: 4] == 4'd0);
      if ((d_q == DW'(k)) && (k != 0)) begin
        blank_c = blz_s && upper_zero_c;
      end
    end
  end

  seg7_decode u_decode (
    .nibble (nibble_c),
    .seg_c  (dec_seg_c)
  );

  assign seg_c       = blank_c ? SEG_BLANK : dec_seg_c;
  assign anode_hot_c = NUM_DIGITS'(1) << d_q;
  assign thresh_c    = (TW'(bright_l) + TW'(1)) * TW'(STEP);
  assign lit_c       = (p_q != '0) && (TW'(p_q) < thresh_c);

  // Slot prescaler and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
      d_q <= '0;
    end else if (!en) begin
      p_q <= '0;
      d_q <= '0;
    end else if (p_last_c) begin
      p_q <= '0;
      d_q <= d_last_c ? '0 : d_q + DW'(1);
    end else begin
      p_q <= p_q + PW'(1);
    end
  end

  // Frame snapshot and per-slot brightness latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_s    <= '0;
      dp_s     <= '0;
      blz_s    <= 1'b0;
      bright_l <= '0;
    end else if (en) begin
      if (frame_start_c) begin
        bcd_s <= bcd_in;
        dp_s  <= dp_in;
        blz_s <= blank_lz;
      end
      if (p_q == '0) begin
        bright_l <= brightness;
      end
    end
  end

  // Registered pin drivers; polarity applied here only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_anode   <= ANODE_OFF;
      seg_cathode <= SEG_OFF;
      seg_dp      <= DP_OFF;
      frame_tick  <= 1'b0;
    end else if (!en) begin
      seg_anode   <= ANODE_OFF;
      seg_cathode <= SEG_OFF;
      seg_dp      <= DP_OFF;
      frame_tick  <= 1'b0;
    end else begin
      seg_anode   <= lit_c ? (anode_hot_c ^ ANODE_OFF) : ANODE_OFF;
      seg_cathode <= lit_c ? (seg_c ^ SEG_OFF) : SEG_OFF;
      seg_dp      <= lit_c ? (dp_sel_c ^ DP_OFF) : DP_OFF;
      frame_tick  <= frame_start_c;
    end
  end

endmodule
